// File: rtl/ov_recovery_ctrl.sv
// Overvoltage recovery sequencer: sheds loads on alarm, opens everything on trip,
// then cools down, clears the monitor and restores loads one at a time.
module ov_recovery_ctrl #(
    parameter int          NUM_LOADS        = 4,
    parameter int          CNT_W            = 24,
    parameter int          SHED_INTERVAL    = 50_000,
    parameter int          RESTORE_INTERVAL = 500_000,
    parameter int          COOLDOWN_CYCLES  = 5_000_000,
    parameter int          CLEAR_TIMEOUT    = 16,
    parameter int          MAX_AUTO_RETRY   = 3,
    parameter logic [15:0] CLEAR_KEY        = 16'hA5C3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 warning,
    input  logic                 alarm,
    input  logic                 tripped,
    input  logic                 auto_restart_en,
    input  logic                 key_valid,
    input  logic [15:0]          key_data,
    output logic                 clear_trip,
    output logic [NUM_LOADS-1:0] load_en,
    output logic                 teg_throttle,
    output logic                 lockout,
    output logic [2:0]           state,
    output logic [1:0]           retry_count
);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        SHED     = 3'd1,
        TRIPPED  = 3'd2,
        COOLDOWN = 3'd3,
        CLEAR    = 3'd4,
        RESTORE  = 3'd5,
        LOCKOUT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] SHED_LAST    = CNT_W'(SHED_INTERVAL - 1);
    localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_INTERVAL - 1);
    localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_AUTO_RETRY);

    state_t           state_q;
    logic [CNT_W-1:0] timer;
    logic             key_match;
    logic             trip_sensitive;

    // Clear the highest-index enabled load (lowest priority goes first).
    function automatic logic [NUM_LOADS-1:0] shed_one(input logic [NUM_LOADS-1:0] en);
        logic [NUM_LOADS-1:0] r;
        logic                 done;
        r    = en;
        done = 1'b0;
        for (int i = NUM_LOADS - 1; i >= 0; i--) begin
            if (!done && r[i]) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    // Enable the lowest-index disabled load (highest priority comes back first).
    function automatic logic [NUM_LOADS-1:0] restore_one(input logic [NUM_LOADS-1:0] en);
        logic [NUM_LOADS-1:0] r;
        logic                 done;
        r    = en;
        done = 1'b0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            if (!done && !r[i]) begin
                r[i] = 1'b1;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] retry_inc(input logic [1:0] cnt);
        return (cnt < RETRY_MAX) ? cnt + 2'd1 : RETRY_MAX;
    endfunction

    assign key_match      = key_valid && (key_data == CLEAR_KEY);
    assign trip_sensitive = (state_q == NORMAL) || (state_q == SHED) ||
                            (state_q == COOLDOWN) || (state_q == RESTORE);
    assign state          = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NORMAL;
            timer        <= '0;
            load_en      <= '1;
            teg_throttle <= 1'b0;
            clear_trip   <= 1'b0;
            lockout      <= 1'b0;
            retry_count  <= 2'd0;
        end else if (tripped && trip_sensitive) begin
            state_q      <= TRIPPED;
            timer        <= '0;
            load_en      <= '0;
            teg_throttle <= 1'b1;
            clear_trip   <= 1'b0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (alarm) begin
                        state_q      <= SHED;
                        load_en      <= shed_one(load_en);
                        teg_throttle <= 1'b1;
                        timer        <= '0;
                    end else if (timer == COOL_LAST) begin
                        retry_count <= 2'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHED: begin
                    if (alarm) begin
                        // With every load already off the timer simply parks.
                        if (load_en != '0) begin
                            if (timer == SHED_LAST) begin
                                load_en <= shed_one(load_en);
                                timer   <= '0;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end else if (!warning) begin
                        state_q      <= RESTORE;
                        teg_throttle <= 1'b0;
                        timer        <= '0;
                    end
                end
                TRIPPED: begin
                    load_en      <= '0;
                    teg_throttle <= 1'b1;
                    if (!warning) begin
                        if (key_match) begin
                            state_q     <= COOLDOWN;
                            retry_count <= 2'd0;
                            timer       <= '0;
                        end else if (auto_restart_en && (retry_count < RETRY_MAX)) begin
                            state_q     <= COOLDOWN;
                            retry_count <= retry_inc(retry_count);
                            timer       <= '0;
                        end else if (retry_count == RETRY_MAX) begin
                            state_q <= LOCKOUT;
                            lockout <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    load_en <= '0;
                    if (!warning && key_match) begin
                        state_q     <= COOLDOWN;
                        retry_count <= 2'd0;
                        lockout     <= 1'b0;
                        timer       <= '0;
                    end
                end
                COOLDOWN: begin
                    if (warning) begin
                        timer <= '0;
                    end else if (timer == COOL_LAST) begin
                        state_q    <= CLEAR;
                        clear_trip <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CLEAR: begin
                    if (!tripped) begin
                        state_q      <= RESTORE;
                        clear_trip   <= 1'b0;
                        teg_throttle <= 1'b0;
                        timer        <= '0;
                    end else if (timer == CLEAR_LAST) begin
                        state_q    <= TRIPPED;
                        clear_trip <= 1'b0;
                        timer      <= '0;
                    end else begin
                        clear_trip <= 1'b1;
                        timer      <= timer + 1'b1;
                    end
                end
                RESTORE: begin
                    teg_throttle <= 1'b0;
                    if (alarm) begin
                        state_q      <= SHED;
                        load_en      <= shed_one(load_en);
                        teg_throttle <= 1'b1;
                        timer        <= '0;
                    end else if (&load_en) begin
                        state_q <= NORMAL;
                        timer   <= '0;
                    end else if (timer == RESTORE_LAST) begin
                        load_en <= restore_one(load_en);
                        timer   <= '0;
                        if (&restore_one(load_en)) begin
                            state_q <= NORMAL;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule
